// File: rtl/regfile_wb_port_if.sv
// Writeback/decode/commit-trace bundle for the integer register file.
// slave = register file, master = pipeline side (writeback/decode/debug).
interface regfile_wb_port_if #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int RETCNT_W = 64
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]     Result_W;
  logic [AW-1:0]       RD_W;
  logic                RegWrite_W;
  logic                insn_vld_W;
  logic [AW-1:0]       rs1_addr_D;
  logic [AW-1:0]       rs2_addr_D;
  logic [XLEN-1:0]     rs1_data_D;
  logic [XLEN-1:0]     rs2_data_D;
  logic                retcnt_clr;
  logic [RETCNT_W-1:0] retcnt;
  logic                cm_vld;
  logic                cm_wen;
  logic [AW-1:0]       cm_rd;
  logic [XLEN-1:0]     cm_data;

  modport slave (
    input  Result_W, RD_W, RegWrite_W, insn_vld_W,
    input  rs1_addr_D, rs2_addr_D, retcnt_clr,
    output rs1_data_D, rs2_data_D, retcnt,
    output cm_vld, cm_wen, cm_rd, cm_data
  );

  modport master (
    output Result_W, RD_W, RegWrite_W, insn_vld_W,
    output rs1_addr_D, rs2_addr_D, retcnt_clr,
    input  rs1_data_D, rs2_data_D, retcnt,
    input  cm_vld, cm_wen, cm_rd, cm_data
  );
endinterface

// File: rtl/regfile_wb_port.sv
// Integer register file: writeback write port, two bypassed decode
// read ports, retired-instruction counter and one-cycle commit trace.
module regfile_wb_port #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int RETCNT_W = 64
) (
  input logic               clk,
  input logic               rst_n,
  regfile_wb_port_if.slave  bus
);

  logic [XLEN-1:0]     r_regs [NREG];
  logic [RETCNT_W-1:0] r_retcnt;
  logic                r_cm_vld;
  logic                r_cm_wen;
  logic [$bits(bus.RD_W)-1:0] r_cm_rd;
  logic [XLEN-1:0]     r_cm_data;

  logic                w_wen;
  logic                w_rs1_zero;
  logic                w_rs2_zero;
  logic                w_rs1_byp;
  logic                w_rs2_byp;
  logic [XLEN-1:0]     w_rs1;
  logic [XLEN-1:0]     w_rs2;

  // x0 writes are dropped here so bypass and trace share one qualifier
  assign w_wen = bus.RegWrite_W && (bus.RD_W != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else if (w_wen) begin
      r_regs[bus.RD_W] <= bus.Result_W;
    end
  end

  assign w_rs1_zero = (bus.rs1_addr_D == '0);
  assign w_rs2_zero = (bus.rs2_addr_D == '0);
  assign w_rs1_byp  = w_wen && (bus.RD_W == bus.rs1_addr_D);
  assign w_rs2_byp  = w_wen && (bus.RD_W == bus.rs2_addr_D);

  always_comb begin
    w_rs1 = r_regs[bus.rs1_addr_D];
    unique case (1'b1)
      w_rs1_zero: w_rs1 = '0;
      w_rs1_byp:  w_rs1 = bus.Result_W;
      default:    w_rs1 = r_regs[bus.rs1_addr_D];
    endcase
  end

  always_comb begin
    w_rs2 = r_regs[bus.rs2_addr_D];
    unique case (1'b1)
      w_rs2_zero: w_rs2 = '0;
      w_rs2_byp:  w_rs2 = bus.Result_W;
      default:    w_rs2 = r_regs[bus.rs2_addr_D];
    endcase
  end

  assign bus.rs1_data_D = w_rs1;
  assign bus.rs2_data_D = w_rs2;

  // clear has priority over a same-cycle retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_retcnt <= '0;
    else if (bus.retcnt_clr)
      r_retcnt <= '0;
    else if (bus.insn_vld_W)
      r_retcnt <= r_retcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cm_vld  <= 1'b0;
      r_cm_wen  <= 1'b0;
      r_cm_rd   <= '0;
      r_cm_data <= '0;
    end else begin
      r_cm_vld  <= bus.insn_vld_W;
      r_cm_wen  <= w_wen;
      r_cm_rd   <= bus.RD_W;
      r_cm_data <= w_wen ? bus.Result_W : '0;
    end
  end

  assign bus.retcnt  = r_retcnt;
  assign bus.cm_vld  = r_cm_vld;
  assign bus.cm_wen  = r_cm_wen;
  assign bus.cm_rd   = r_cm_rd;
  assign bus.cm_data = r_cm_data;

endmodule

// File: tb/tb_regfile_wb_port.sv
// Bench for regfile_wb_port: directed scenarios plus a random run
// against a reference array and a commit-trace scoreboard.
module tb_regfile_wb_port;

  logic clk;
  logic rst_n;

  regfile_wb_port_if #(.XLEN(32), .NREG(32), .RETCNT_W(64)) bus ();
  regfile_wb_port_if #(.XLEN(32), .NREG(32), .RETCNT_W(8))  b8 ();

  regfile_wb_port #(.XLEN(32), .NREG(32), .RETCNT_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  regfile_wb_port #(.XLEN(32), .NREG(32), .RETCNT_W(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } cm_t;

  cm_t         exp_q[$];
  cm_t         exp_cm;
  logic [31:0] m_regs [32];
  logic [63:0] m_ret;
  int          checks;
  int          failures;

  logic        cur_we;
  logic [4:0]  cur_rd;
  logic [31:0] cur_data;
  logic        cur_vld;
  logic        cur_clr;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_ret = '0;
    exp_q.delete();
  endtask

  // Drive one writeback/decode cycle at negedge and push the expected trace
  task automatic drv(input logic we, input logic [4:0] rd,
                     input logic [31:0] data, input logic vld,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input logic clr);
    cm_t e;
    @(negedge clk);
    bus.RegWrite_W = we;
    bus.RD_W       = rd;
    bus.Result_W   = data;
    bus.insn_vld_W = vld;
    bus.rs1_addr_D = a1;
    bus.rs2_addr_D = a2;
    bus.retcnt_clr = clr;
    cur_we = we; cur_rd = rd; cur_data = data;
    cur_vld = vld; cur_clr = clr;
    e.vld  = vld;
    e.wen  = we && (rd != 5'd0);
    e.rd   = rd;
    e.data = e.wen ? data : 32'd0;
    exp_q.push_back(e);
  endtask

  // Advance one edge, update the reference model, pop the expected trace
  task automatic tick();
    @(posedge clk);
    if (cur_we && cur_rd != 5'd0) m_regs[cur_rd] = cur_data;
    if (cur_clr) m_ret = '0;
    else if (cur_vld) m_ret = m_ret + 64'd1;
    if (exp_q.size() > 0) exp_cm = exp_q.pop_front();
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.retcnt !== 64'd0 || bus.cm_vld !== 1'b0 ||
        bus.cm_wen !== 1'b0 || bus.cm_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_init: retcnt=%0h cm_vld=%b cm_wen=%b cm_data=%h want 0",
               bus.retcnt, bus.cm_vld, bus.cm_wen, bus.cm_data);
    end
    drv(1'b1, 5'd9, 32'h1111_2222, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd9, 1'b0);
    #2;
    checks++;
    if (bus.rs1_data_D !== 32'h1111_2222 || bus.retcnt !== 64'd1) begin
      failures++;
      $display("FAIL reset_pre: rs1=%h retcnt=%0d want 11112222 1",
               bus.rs1_data_D, bus.retcnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.retcnt !== 64'd0 || bus.cm_vld !== 1'b0 ||
        bus.rs1_data_D !== 32'd0 || bus.rs2_data_D !== 32'd0) begin
      failures++;
      $display("FAIL reset_async: retcnt=%0d cm_vld=%b rs1=%h rs2=%h want 0",
               bus.retcnt, bus.cm_vld, bus.rs1_data_D, bus.rs2_data_D);
    end
    for (int a = 0; a < 32; a++) begin
      bus.rs1_addr_D = 5'(a);
      bus.rs2_addr_D = 5'(31 - a);
      #1;
      checks++;
      if (bus.rs1_data_D !== 32'd0 || bus.rs2_data_D !== 32'd0) begin
        failures++;
        $display("FAIL reset_read a=%0d: rs1=%h rs2=%h want 0",
                 a, bus.rs1_data_D, bus.rs2_data_D);
      end
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    drv(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd0, 32'h0000_1234, 1'b1, 5'd5, 5'd0, 1'b0);
    #2;
    checks++;
    if (bus.rs1_data_D !== 32'hDEAD_BEEF || bus.rs2_data_D !== 32'd0) begin
      failures++;
      $display("FAIL write_x5: rs1=%h rs2=%h want deadbeef 0",
               bus.rs1_data_D, bus.rs2_data_D);
    end
    tick();
    checks++;
    if (bus.cm_wen !== 1'b0 || bus.cm_vld !== 1'b1 || bus.cm_data !== 32'd0) begin
      failures++;
      $display("FAIL write_x0_trace: cm_wen=%b cm_vld=%b cm_data=%h want 0 1 0",
               bus.cm_wen, bus.cm_vld, bus.cm_data);
    end
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 1'b0);
    #2;
    checks++;
    if (bus.rs1_data_D !== 32'd0 || bus.rs2_data_D !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_x0_read: rs1=%h rs2=%h want 0 deadbeef",
               bus.rs1_data_D, bus.rs2_data_D);
    end
    tick();
  endtask

  task automatic test_bypass();
    drv(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd7, 5'd7, 1'b0);
    #2;
    checks++;
    if (bus.rs1_data_D !== 32'hA5A5_A5A5 || bus.rs2_data_D !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL bypass_both: rs1=%h rs2=%h want a5a5a5a5",
               bus.rs1_data_D, bus.rs2_data_D);
    end
    tick();
    drv(1'b1, 5'd7, 32'h0F0F_0F0F, 1'b0, 5'd7, 5'd5, 1'b0);
    #2;
    checks++;
    if (bus.rs1_data_D !== 32'h0F0F_0F0F || bus.rs2_data_D !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL bypass_one: rs1=%h rs2=%h want 0f0f0f0f deadbeef",
               bus.rs1_data_D, bus.rs2_data_D);
    end
    tick();
  endtask

  task automatic test_retire();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b0);
      tick();
    end
    checks++;
    if (bus.retcnt !== 64'd10) begin
      failures++;
      $display("FAIL retire_count: retcnt=%0d want 10", bus.retcnt);
    end
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b1);
    tick();
    checks++;
    if (bus.retcnt !== 64'd0) begin
      failures++;
      $display("FAIL retire_clr_wins: retcnt=%0d want 0", bus.retcnt);
    end
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic test_wrap();
    @(negedge clk);
    b8.retcnt_clr = 1'b1;
    @(negedge clk);
    b8.retcnt_clr = 1'b0;
    b8.insn_vld_W = 1'b1;
    repeat (255) @(posedge clk);
    #1;
    checks++;
    if (b8.retcnt !== 8'd255) begin
      failures++;
      $display("FAIL wrap_255: retcnt=%0d want 255", b8.retcnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (b8.retcnt !== 8'd0) begin
      failures++;
      $display("FAIL wrap_0: retcnt=%0d want 0", b8.retcnt);
    end
    @(negedge clk);
    b8.insn_vld_W = 1'b0;
  endtask

  task automatic test_commit();
    drv(1'b1, 5'd3, 32'h0000_0042, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    checks++;
    if (bus.cm_vld !== 1'b1 || bus.cm_wen !== 1'b1 ||
        bus.cm_rd !== 5'd3 || bus.cm_data !== 32'h42) begin
      failures++;
      $display("FAIL commit_wr: vld=%b wen=%b rd=%0d data=%h want 1 1 3 42",
               bus.cm_vld, bus.cm_wen, bus.cm_rd, bus.cm_data);
    end
    drv(1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    checks++;
    if (bus.cm_vld !== 1'b0 || bus.cm_wen !== 1'b0 || bus.cm_data !== 32'd0) begin
      failures++;
      $display("FAIL commit_bubble: vld=%b wen=%b data=%h want 0 0 0",
               bus.cm_vld, bus.cm_wen, bus.cm_data);
    end
  endtask

  task automatic test_random();
    logic        we, vld;
    logic [4:0]  rd, a1, a2;
    logic [31:0] data, e1, e2;
    int          bad;
    bad = 0;
    for (int n = 0; n < 10000; n++) begin
      we   = 1'($urandom_range(0, 1));
      vld  = 1'($urandom_range(0, 1));
      rd   = 5'($urandom_range(0, 31));
      a1   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      data = $urandom;
      drv(we, rd, data, vld, a1, a2, 1'b0);
      e1 = (a1 == 5'd0) ? 32'd0 : (we && rd == a1) ? data : m_regs[a1];
      e2 = (a2 == 5'd0) ? 32'd0 : (we && rd == a2) ? data : m_regs[a2];
      #2;
      checks++;
      if (bus.rs1_data_D !== e1 || bus.rs2_data_D !== e2) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL rand_read n=%0d a1=%0d a2=%0d: rs1=%h rs2=%h want %h %h",
                   n, a1, a2, bus.rs1_data_D, bus.rs2_data_D, e1, e2);
      end
      tick();
      checks++;
      if (bus.cm_vld !== exp_cm.vld || bus.cm_wen !== exp_cm.wen ||
          bus.cm_rd !== exp_cm.rd || bus.cm_data !== exp_cm.data) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL rand_trace n=%0d: %b %b %0d %h want %b %b %0d %h",
                   n, bus.cm_vld, bus.cm_wen, bus.cm_rd, bus.cm_data,
                   exp_cm.vld, exp_cm.wen, exp_cm.rd, exp_cm.data);
      end
    end
    checks++;
    if (bus.retcnt !== m_ret) begin
      failures++;
      $display("FAIL rand_retcnt: retcnt=%0d want %0d", bus.retcnt, m_ret);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.RegWrite_W = 1'b0; bus.RD_W = '0; bus.Result_W = '0;
    bus.insn_vld_W = 1'b0; bus.rs1_addr_D = '0; bus.rs2_addr_D = '0;
    bus.retcnt_clr = 1'b0;
    b8.RegWrite_W = 1'b0; b8.RD_W = '0; b8.Result_W = '0;
    b8.insn_vld_W = 1'b0; b8.rs1_addr_D = '0; b8.rs2_addr_D = '0;
    b8.retcnt_clr = 1'b0;
    cur_we = 1'b0; cur_rd = '0; cur_data = '0; cur_vld = 1'b0; cur_clr = 1'b0;
    exp_cm = '{vld: 1'b0, wen: 1'b0, rd: 5'd0, data: 32'd0};
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_write();
    test_bypass();
    test_retire();
    test_wrap();
    test_commit();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
